// File: rtl/rgb2gray_arbiter.sv
// rgb2gray_arbiter: round-robin sharing of one rgb2gray unit among several RGB streams, with in-order result steering
module rgb2gray_arbiter #(
  parameter int width_p        = 8,
  parameter int num_req_p      = 4,
  parameter int max_inflight_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 req_valid_i,
  output logic [num_req_p-1:0]                 req_ready_o,
  input  logic [num_req_p*3*width_p-1:0]       req_rgb_i,
  output logic [width_p-1:0]                   dp_red_o,
  output logic [width_p-1:0]                   dp_green_o,
  output logic [width_p-1:0]                   dp_blue_o,
  output logic                                 dp_valid_o,
  input  logic                                 dp_ready_i,
  input  logic [width_p-1:0]                   dp_gray_i,
  input  logic                                 dp_valid_i,
  output logic                                 dp_ready_o,
  output logic [num_req_p-1:0]                 resp_valid_o,
  input  logic [num_req_p-1:0]                 resp_ready_i,
  output logic [width_p-1:0]                   resp_gray_o,
  output logic [$clog2(max_inflight_p+1)-1:0]  inflight_o,
  output logic                                 err_o
);
  localparam int id_w  = $clog2(num_req_p);
  localparam int cw    = id_w + 1;
  localparam int ptr_w = max_inflight_p > 1 ? $clog2(max_inflight_p) : 1;
  localparam int cnt_w = $clog2(max_inflight_p + 1);
  localparam logic [0:0] arb_s  = 1'b0;
  localparam logic [0:0] hold_s = 1'b1;
  logic [0:0]       state_r;
  logic [id_w-1:0]  rr_r, grant_r, arb_idx, grant, head_id;
  logic [id_w-1:0]  tag_mem [max_inflight_p];
  logic [ptr_w-1:0] head_r, tail_r;
  logic [cnt_w-1:0] count_r;
  logic [cw-1:0]    cand;
  logic             arb_found, full, empty, issue, push, pop;
  // first valid requester at or after the rr pointer; scanning downward leaves the nearest one
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_r;
    cand      = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = {1'b0, rr_r} + cw'(i);
      cand = cand >= cw'(num_req_p) ? cand - cw'(num_req_p) : cand;
      if (req_valid_i[cand[id_w-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[id_w-1:0];
      end
    end
  end
  assign grant        = state_r == hold_s ? grant_r : arb_idx;
  assign full         = count_r == cnt_w'(max_inflight_p);
  assign empty        = count_r == '0;
  assign issue        = ~reset_i & ~full & (state_r == hold_s | arb_found);
  assign push         = issue & dp_ready_i;
  assign head_id      = tag_mem[head_r];
  assign pop          = ~reset_i & dp_valid_i & ~empty & resp_ready_i[head_id];
  assign dp_valid_o   = issue;
  assign {dp_red_o, dp_green_o, dp_blue_o} = req_rgb_i[grant*3*width_p +: 3*width_p];
  assign req_ready_o  = push ? num_req_p'(1'b1) << grant : '0;
  assign resp_valid_o = (~reset_i & dp_valid_i & ~empty) ? num_req_p'(1'b1) << head_id : '0;
  assign dp_ready_o   = ~reset_i & (empty ? dp_valid_i : resp_ready_i[head_id]);
  assign resp_gray_o  = dp_gray_i;
  assign inflight_o   = count_r;
  // grant FSM: a stalled issue freezes the grant until the datapath accepts it
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= arb_s;
      rr_r    <= '0;
      grant_r <= '0;
    end else if (push) begin
      state_r <= arb_s;
      rr_r    <= grant == id_w'(num_req_p - 1) ? '0 : grant + 1'b1;
    end else if (issue) begin
      state_r <= hold_s;
      grant_r <= grant;
    end
  end
  // in-order tag FIFO recording the owner of every pixel inside the datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) tag_mem[tail_r] <= grant;
      tail_r  <= push ? tail_r + 1'b1 : tail_r;
      head_r  <= pop ? head_r + 1'b1 : head_r;
      count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
    end
  end
  // sticky flag for an orphan result arriving with no owner recorded
  always_ff @(posedge clk_i) begin
    if (reset_i) err_o <= 1'b0;
    else err_o <= err_o | (dp_valid_i & empty);
  end
endmodule
